// File: rtl/online_pkg.sv
// online_pkg: signed-digit encoding constants and width helpers shared by the online CCM datapath.
package online_pkg;
   localparam logic [1:0] DIG_P = 2'b10;
   localparam logic [1:0] DIG_N = 2'b01;
   localparam logic [1:0] DIG_Z = 2'b00;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int y_width(input int stage, input int sw, input int nterm);
      return 2 * (stage + (1 << sw) - 1 + clog2(nterm));
   endfunction
endpackage

// File: rtl/online_adder.sv
// online_adder: exact sum of two N-digit borrow-save operands into N+1 digits.
// Positive and negative rails are summed separately, so the result digit value is exactly a+b+cin.
module online_adder #(
   parameter int N = 8
) (
   input  logic [2*N-1:0] a,
   input  logic [2*N-1:0] b,
   input  logic           cin,
   output logic [2*N+1:0] s
);
   logic [N-1:0] ap, an, bp, bn;
   logic [N:0]   sp, sn;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         ap[i] = a[2*i+1];
         an[i] = a[2*i];
         bp[i] = b[2*i+1];
         bn[i] = b[2*i];
      end
      sp = {1'b0, ap} + {1'b0, bp} + {{N{1'b0}}, cin};
      sn = {1'b0, an} + {1'b0, bn};
      for (int i = 0; i <= N; i++) begin
         s[2*i+1] = sp[i];
         s[2*i]   = sn[i];
      end
   end
endmodule

// File: rtl/online_ccm_pipe.sv
// online_ccm_pipe: pipelined multiplier of a signed-digit sample by a runtime-loadable
// sum of up to NTERM signed power-of-two terms, with valid/ready flow control.
module online_ccm_pipe
   import online_pkg::*;
#(
   parameter  int STAGE = 4,
   parameter  int NTERM = 4,
   parameter  int SW    = 3,
   localparam int SMAX  = (1 << SW) - 1,
   localparam int LVL   = clog2(NTERM),
   localparam int F0    = STAGE + SMAX,
   localparam int YW    = y_width(STAGE, SW, NTERM)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2*STAGE-1:0]    x,
   input  logic                  coef_load,
   input  logic [NTERM*SW-1:0]   coef_shift,
   input  logic [NTERM-1:0]      coef_neg,
   input  logic [NTERM-1:0]      coef_en,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [YW-1:0]         y
);
   // Default coefficient 41 = 2^5 + 2^3 + 2^0
   localparam logic [NTERM*SW-1:0] DEF_SHIFT = (NTERM*SW)'(5 + (3 << SW));
   localparam logic [NTERM-1:0]    DEF_EN    = (NTERM)'(7);

   logic [NTERM*SW-1:0] coef_shift_q, coef_shift_d;
   logic [NTERM-1:0]    coef_neg_q, coef_neg_d, coef_en_q, coef_en_d;
   logic [LVL:0]        v_q, v_d;
   logic [2*STAGE-1:0]  xn [NTERM];
   logic [2*F0-1:0]     term_q [NTERM], term_d [NTERM];
   logic                adv, acc;

   assign out_valid = v_q[LVL];
   assign adv       = ~(out_valid & ~out_ready);
   assign in_ready  = adv;
   assign acc       = in_valid & in_ready;

   always_comb begin
      coef_shift_d = coef_load ? coef_shift : coef_shift_q;
      coef_neg_d   = coef_load ? coef_neg   : coef_neg_q;
      coef_en_d    = coef_load ? coef_en    : coef_en_q;
      v_d          = adv ? {v_q[LVL-1:0], acc} : v_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         coef_shift_q <= DEF_SHIFT;
         coef_neg_q   <= '0;
         coef_en_q    <= DEF_EN;
         v_q          <= '0;
      end else begin
         coef_shift_q <= coef_shift_d;
         coef_neg_q   <= coef_neg_d;
         coef_en_q    <= coef_en_d;
         v_q          <= v_d;
      end
   end

   // Negation swaps the rails of every digit; the shift moves whole digits (two bits each)
   always_comb begin
      for (int k = 0; k < NTERM; k++) begin
         for (int i = 0; i < STAGE; i++)
            xn[k][2*i +: 2] = coef_neg_q[k] ? {x[2*i], x[2*i+1]} : x[2*i +: 2];
         term_d[k] = !adv ? term_q[k] :
                     !coef_en_q[k] ? '0 :
                     {{(2*SMAX){1'b0}}, xn[k]} << {coef_shift_q[k*SW +: SW], 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < NTERM; k++)
         term_q[k] <= rst ? '0 : term_d[k];
   end

   for (genvar l = 1; l <= LVL; l++) begin : g_lvl
      localparam int N = NTERM >> l;
      localparam int W = F0 + l;
      logic [2*W-3:0] a [2*N];
      logic [2*W-1:0] s [N], sum_d [N], sum_q [N];
      if (l == 1) begin : g_src
         assign a = term_q;
      end else begin : g_src
         assign a = g_lvl[l-1].sum_q;
      end
      for (genvar j = 0; j < N; j++) begin : g_add
         online_adder #(.N(W-1)) u_add (
            .a   (a[2*j]),
            .b   (a[2*j+1]),
            .cin (1'b0),
            .s   (s[j])
         );
      end
      always_comb begin
         for (int j = 0; j < N; j++)
            sum_d[j] = adv ? s[j] : sum_q[j];
      end
      always_ff @(posedge clk) begin
         for (int j = 0; j < N; j++)
            sum_q[j] <= rst ? '0 : sum_d[j];
      end
   end

   assign y = g_lvl[LVL].sum_q[0];
endmodule

// File: tb/tb_online_ccm_pipe.sv
// tb_online_ccm_pipe: directed checks of value, latency, coefficient loading, stall and reset.
module tb_online_ccm_pipe;
   localparam int YW = 26;

   logic          clk = 1'b0;
   logic          rst, in_valid, in_ready, coef_load, out_valid, out_ready;
   logic [7:0]    x;
   logic [11:0]   coef_shift;
   logic [3:0]    coef_neg, coef_en;
   logic [YW-1:0] y;
   int            n_vec = 0;
   int            n_bad = 0;

   always #5 clk = ~clk;

   online_ccm_pipe dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .x          (x),
      .coef_load  (coef_load),
      .coef_shift (coef_shift),
      .coef_neg   (coef_neg),
      .coef_en    (coef_en),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .y          (y)
   );

   function automatic logic [7:0] enc(input int v);
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) if (v[i]) r[2*i +: 2] = 2'b10;
      return r;
   endfunction

   function automatic int val(input logic [YW-1:0] v);
      int r;
      r = 0;
      for (int i = 0; i < YW/2; i++) r += ((v[2*i+1] ? 1 : 0) - (v[2*i] ? 1 : 0)) * (1 << i);
      return r;
   endfunction

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; coef_load = 1'b0; out_ready = 1'b1;
      x = '0; coef_shift = '0; coef_neg = '0; coef_en = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic load_coef(input logic [11:0] sh, input logic [3:0] ng, input logic [3:0] en);
      coef_load = 1'b1; coef_shift = sh; coef_neg = ng; coef_en = en;
      @(posedge clk);
      #1 coef_load = 1'b0;
   endtask

   task automatic send_and_wait(input logic [7:0] xv, output int got, output int lat);
      x = xv; in_valid = 1'b1; lat = 0; got = 0;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk);
         #1 in_valid = 1'b0;
         if (out_valid) begin
            lat = c; got = val(y);
            break;
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_vec++; if (y !== '0) begin n_bad++; $display("FAIL reset_y: got %h expected 0", y); end
      n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_single();
      int got, lat;
      do_reset();
      send_and_wait(8'b10101010, got, lat);
      n_vec++; if (lat !== 3) begin n_bad++; $display("FAIL latency: got %0d expected 3", lat); end
      n_vec++; if (got !== 615) begin n_bad++; $display("FAIL x15: got %0d expected 615", got); end
      send_and_wait(8'b00000001, got, lat);
      n_vec++; if (got !== -41) begin n_bad++; $display("FAIL xm1: got %0d expected -41", got); end
      send_and_wait(8'b11111111, got, lat);
      n_vec++; if (got !== 0) begin n_bad++; $display("FAIL x11: got %0d expected 0", got); end
   endtask

   task automatic test_back_to_back();
      int got[$];
      do_reset();
      x = enc(3); in_valid = 1'b1;
      coef_load = 1'b1; coef_shift = 12'h007; coef_neg = 4'b0010; coef_en = 4'b0011;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         #1 coef_load = 1'b0;
         in_valid = 1'b0;
         if (out_valid) got.push_back(val(y));
         if (c == 0) in_valid = 1'b1;
      end
      in_valid = 1'b0;
      n_vec++; if (got.size() !== 2) begin n_bad++; $display("FAIL b2b_count: got %0d expected 2", got.size()); end
      if (got.size() == 2) begin
         n_vec++; if (got[0] !== 123) begin n_bad++; $display("FAIL b2b_old_coef: got %0d expected 123", got[0]); end
         n_vec++; if (got[1] !== 381) begin n_bad++; $display("FAIL b2b_new_coef: got %0d expected 381", got[1]); end
      end
   endtask

   task automatic test_stall();
      int got[$];
      int idx, stalls;
      do_reset();
      idx = 0; stalls = 0;
      for (int c = 0; c < 40; c++) begin
         x = enc(idx + 1);
         in_valid = (idx < 5);
         out_ready = !(out_valid && stalls < 4);
         if (!out_ready) stalls++;
         #2;
         if (out_valid && !out_ready) begin
            n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
         end
         if (out_valid && out_ready) got.push_back(val(y));
         if (in_valid && in_ready) idx++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      n_vec++; if (stalls !== 4) begin n_bad++; $display("FAIL stall_cycles: got %0d expected 4", stalls); end
      n_vec++; if (idx !== 5) begin n_bad++; $display("FAIL stall_accepted: got %0d expected 5", idx); end
      n_vec++; if (got.size() !== 5) begin n_bad++; $display("FAIL stall_count: got %0d expected 5", got.size()); end
      for (int i = 0; i < got.size() && i < 5; i++) begin
         n_vec++; if (got[i] !== 41 * (i + 1)) begin n_bad++; $display("FAIL stall_out%0d: got %0d expected %0d", i, got[i], 41 * (i + 1)); end
      end
   endtask

   task automatic test_reset_midstream();
      int got, lat, seen;
      do_reset();
      load_coef(12'h007, 4'b0000, 4'b0001);
      in_valid = 1'b1; x = enc(1);
      @(posedge clk);
      #1 x = enc(2);
      @(posedge clk);
      #1 in_valid = 1'b0; rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
      n_vec++; if (y !== '0) begin n_bad++; $display("FAIL midrst_y: got %h expected 0", y); end
      seen = 0;
      repeat (5) begin
         @(posedge clk);
         #1 if (out_valid) seen++;
      end
      n_vec++; if (seen !== 0) begin n_bad++; $display("FAIL midrst_stale: got %0d outputs expected 0", seen); end
      send_and_wait(enc(2), got, lat);
      n_vec++; if (got !== 82) begin n_bad++; $display("FAIL midrst_default_coef: got %0d expected 82", got); end
      n_vec++; if (lat !== 3) begin n_bad++; $display("FAIL midrst_latency: got %0d expected 3", lat); end
   endtask

   task automatic test_extremes();
      int got, lat;
      do_reset();
      load_coef(12'hFFF, 4'b0000, 4'b1111);
      send_and_wait(enc(15), got, lat);
      n_vec++; if (got !== 7680) begin n_bad++; $display("FAIL max_range: got %0d expected 7680", got); end
      load_coef(12'hFFF, 4'b0000, 4'b0000);
      send_and_wait(enc(15), got, lat);
      n_vec++; if (got !== 0) begin n_bad++; $display("FAIL all_disabled: got %0d expected 0", got); end
      n_vec++; if (lat !== 3) begin n_bad++; $display("FAIL disabled_latency: got %0d expected 3", lat); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_reset_midstream();
      test_extremes();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
